vga_frame_streamer: RTL

//  Producer side of the VGA pixel-stream interface. Waits for the display's per-frame ready pulse.

---
 rtl/vga_frame_streamer.sv | 111 +++++++++++
 1 files changed

// File: rtl/vga_frame_streamer.sv
// Streams one full raster frame to the VGA controller per ready pulse, filling the
// window from the GPU framebuffer and everything else with zero.
module vga_frame_streamer #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 525,
  parameter int WIN_X0     = 295,
  parameter int WIN_Y0     = 215,
  parameter int WIN_W      = 50,
  parameter int WIN_H      = 50,
  parameter int PIX_W      = 6,
  parameter int ADDR_W     = 12,
  parameter int AUTO_START = 1
) (
  input  logic              clk_20,
  input  logic              reset,
  input  logic              vga_ready_in,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [PIX_W-1:0]  fb_rd_data,
  output logic              vga_data_valid_out,
  output logic [PIX_W-1:0]  vga_data_out,
  output logic              frame_done,
  output logic              busy
);

  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(WIN_W*WIN_H-1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t            state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pending_q, started_q;
  logic              vld_q, win_q, done_q, busy_q;
  logic              in_win_d, last_px_d, eol_d;

  always_comb begin
    in_win_d  = (int'(x_q) >= WIN_X0) && (int'(x_q) < WIN_X0 + WIN_W) &&
                (int'(y_q) >= WIN_Y0) && (int'(y_q) < WIN_Y0 + WIN_H);
    eol_d     = (int'(x_q) == SCREEN_W - 1);
    last_px_d = eol_d && (int'(y_q) == SCREEN_H - 1);
  end

  // Stage 0 drives the read straight from the counters so the synchronous
  // framebuffer data lines up with the stage-1 valid register.
  assign fb_rd_en           = (state_q == STREAM) && in_win_d;
  assign fb_rd_addr         = addr_q;
  assign vga_data_valid_out = vld_q;
  assign vga_data_out       = win_q ? fb_rd_data : '0;
  assign frame_done         = done_q;
  assign busy               = busy_q;

  always_ff @(posedge clk_20 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      pending_q <= 1'b0;
      started_q <= 1'b0;
      vld_q     <= 1'b0;
      win_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      started_q <= 1'b1;
      done_q    <= 1'b0;
      vld_q     <= (state_q == STREAM);
      win_q     <= fb_rd_en;
      case (state_q)
        IDLE: begin
          if (vga_ready_in || pending_q) begin
            state_q   <= STREAM;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
          end else if (AUTO_START != 0 && !started_q) begin
            pending_q <= 1'b1;
          end
        end
        STREAM: begin
          if (vga_ready_in) pending_q <= 1'b1;
          if (fb_rd_en && addr_q != FB_LAST) addr_q <= addr_q + 1'b1;
          if (last_px_d) begin
            state_q <= DRAIN;
            x_q     <= '0;
            y_q     <= '0;
          end else if (eol_d) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        DRAIN: begin
          if (vga_ready_in) pending_q <= 1'b1;
          state_q <= IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
